vend_fsm_param: RTL and testbench

- Parametrised successor to the fixed-price nickel/dime vending FSM.
- Accepts nickels, dimes and quarters, and vends at a programmable price.
- Returns change as a sequence of dime/nickel pulses and supports a cancel/refund request.
- Sits between the coin-acceptor front end and the item/coin-return actuators.

---
 rtl/vend_pkg.sv | 15 +
 rtl/vend_fsm_param_if.sv | 37 +++
 rtl/vend_coin_decode.sv | 29 ++
 rtl/vend_fsm_param.sv | 103 ++++++++++
 tb/tb_vend_fsm_param.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared types and coin values for the parametrised vending controller.
// State encoding plus the credit value of each accepted coin, in nickels.
package vend_pkg;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      VEND   = 2'd1,
      CHANGE = 2'd2
   } state_t;

   localparam logic [2:0] NICKEL_V  = 3'd1;
   localparam logic [2:0] DIME_V    = 3'd2;
   localparam logic [2:0] QUARTER_V = 3'd5;

endpackage

// File: rtl/vend_fsm_param_if.sv
// Coin-acceptor / actuator bundle for vend_fsm_param.
// sales_count exists only when VEND_SALES_COUNT_EN is defined.
interface vend_fsm_param_if #(
   parameter int CREDIT_W = 5,
   parameter int SALES_W  = 8
);

   logic                nickel_in;
   logic                dime_in;
   logic                quarter_in;
   logic                cancel;
   logic                dispense;
   logic                dime_out;
   logic                nickel_out;
   logic                busy;
   logic [CREDIT_W-1:0] credit;
`ifdef VEND_SALES_COUNT_EN
   logic [SALES_W-1:0]  sales_count;
`endif

   modport master (
      output nickel_in, dime_in, quarter_in, cancel,
      input  dispense, dime_out, nickel_out, busy, credit
`ifdef VEND_SALES_COUNT_EN
      , input sales_count
`endif
   );

   modport slave (
      input  nickel_in, dime_in, quarter_in, cancel,
      output dispense, dime_out, nickel_out, busy, credit
`ifdef VEND_SALES_COUNT_EN
      , output sales_count
`endif
   );

endinterface

// File: rtl/vend_coin_decode.sv
// Priority encoder from coin pulses to an accepted flag and credit value.
// Quarter beats dime beats nickel; losing pulses are dropped.
module vend_coin_decode
   import vend_pkg::*;
(
   input  logic       nickel,
   input  logic       dime,
   input  logic       quarter,
   output logic       accepted,
   output logic [2:0] value
);

   // Pick the single highest-value coin present this cycle.
   always_comb begin
      accepted = 1'b0;
      value    = 3'd0;
      if (quarter) begin
         accepted = 1'b1;
         value    = QUARTER_V;
      end else if (dime) begin
         accepted = 1'b1;
         value    = DIME_V;
      end else if (nickel) begin
         accepted = 1'b1;
         value    = NICKEL_V;
      end
   end

endmodule

// File: rtl/vend_fsm_param.sv
// Programmable-price vending FSM: accumulate, vend, return change.
// Optional sales counter enabled by VEND_SALES_COUNT_EN.
module vend_fsm_param
   import vend_pkg::*;
#(
   parameter int PRICE_N  = 5,
   parameter int CREDIT_W = 5,
   parameter int SALES_W  = 8
) (
   input  logic clock,
   input  logic reset,
   vend_fsm_param_if.slave bus
);

   if (PRICE_N < 1) begin : g_price_chk
      $error("vend_fsm_param: PRICE_N must be >= 1");
   end
   if ((2 ** CREDIT_W) <= (PRICE_N + 4)) begin : g_width_chk
      $error("vend_fsm_param: CREDIT_W too small for PRICE_N+4");
   end

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_N);
   localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);
   localparam logic [CREDIT_W-1:0] TWO_C   = CREDIT_W'(2);

   state_t              state;
   state_t              state_nxt;
   logic [CREDIT_W-1:0] credit_q;
   logic [CREDIT_W-1:0] credit_nxt;
   logic [CREDIT_W-1:0] sum;
   logic                coin_ok;
   logic [2:0]          coin_val;

   vend_coin_decode u_dec (
      .nickel   (bus.nickel_in),
      .dime     (bus.dime_in),
      .quarter  (bus.quarter_in),
      .accepted (coin_ok),
      .value    (coin_val)
   );

   assign sum = credit_q + CREDIT_W'(coin_val);

   // State and credit registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ACCUM;
         credit_q <= '0;
      end else begin
         state    <= state_nxt;
         credit_q <= credit_nxt;
      end
   end

   // Next state and credit; inputs only matter while accumulating.
   always_comb begin
      state_nxt  = state;
      credit_nxt = credit_q;
      unique case (state)
         ACCUM: begin
            if (bus.cancel && credit_q != '0) begin
               state_nxt = CHANGE;
            end else if (coin_ok) begin
               credit_nxt = sum;
               if (sum >= PRICE_C) state_nxt = VEND;
            end
         end
         VEND: begin
            credit_nxt = credit_q - PRICE_C;
            if (credit_q == PRICE_C) state_nxt = ACCUM;
            else                     state_nxt = CHANGE;
         end
         CHANGE: begin
            if (credit_q >= TWO_C) credit_nxt = credit_q - TWO_C;
            else if (credit_q == ONE_C) credit_nxt = '0;
            if (credit_nxt == '0) state_nxt = ACCUM;
         end
         default: begin
            state_nxt  = ACCUM;
            credit_nxt = '0;
         end
      endcase
   end

   assign bus.dispense   = (state == VEND);
   assign bus.dime_out   = (state == CHANGE) && (credit_q >= TWO_C);
   assign bus.nickel_out = (state == CHANGE) && (credit_q == ONE_C);
   assign bus.busy       = (state != ACCUM);
   assign bus.credit     = credit_q;

`ifdef VEND_SALES_COUNT_EN
   logic [SALES_W-1:0] sales_q;

   // Count vends, holding at all-ones once full.
   always_ff @(posedge clock) begin
      if (reset) sales_q <= '0;
      else if (state == VEND && sales_q != '1) sales_q <= sales_q + 1'b1;
   end

   assign bus.sales_count = sales_q;
`endif

endmodule

// File: tb/tb_vend_fsm_param.sv
// Randomised + directed bench for vend_fsm_param against a queue model.
// Define VEND_SALES_COUNT_EN to also check the sales counter.
module tb_vend_fsm_param;

   localparam int PRICE_N  = 5;
   localparam int CREDIT_W = 5;
   localparam int SALES_W  = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;

   vend_fsm_param_if #(.CREDIT_W(CREDIT_W), .SALES_W(SALES_W)) bus ();

   vend_fsm_param #(
      .PRICE_N  (PRICE_N),
      .CREDIT_W (CREDIT_W),
      .SALES_W  (SALES_W)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: credit in nickels and a queue of pending busy-cycle actions.
   // 1 = dispense, 2 = dime back, 3 = nickel back.
   int cr = 0;
   int acts[$];
   int sales = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_change(int r);
      repeat (r / 2) acts.push_back(2);
      if (r % 2 != 0) acts.push_back(3);
   endtask

   task automatic check_outs();
      int a;
      a = (acts.size() > 0) ? acts[0] : 0;
      chk("dispense",   32'(bus.dispense),   32'(a == 1));
      chk("dime_out",   32'(bus.dime_out),   32'(a == 2));
      chk("nickel_out", 32'(bus.nickel_out), 32'(a == 3));
      chk("busy",       32'(bus.busy),       32'(a != 0));
      chk("credit",     32'(bus.credit),     32'(cr));
`ifdef VEND_SALES_COUNT_EN
      chk("sales_count", 32'(bus.sales_count), 32'(sales));
`endif
   endtask

   task automatic cyc(bit n, bit d, bit q, bit c, bit rst);
      int a;
      check_outs();
      bus.nickel_in  = n;
      bus.dime_in    = d;
      bus.quarter_in = q;
      bus.cancel     = c;
      reset          = rst;
      @(posedge clock);
      if (rst) begin
         cr = 0;
         acts.delete();
         sales = 0;
      end else if (acts.size() > 0) begin
         a = acts.pop_front();
         if (a == 1) begin
            cr -= PRICE_N;
            if (sales < (1 << SALES_W) - 1) sales++;
            if (cr > 0) push_change(cr);
         end else if (a == 2) begin
            cr -= 2;
         end else begin
            cr -= 1;
         end
      end else if (c && cr > 0) begin
         push_change(cr);
      end else begin
         cr += q ? 5 : d ? 2 : n ? 1 : 0;
         if (cr >= PRICE_N) acts.push_back(1);
      end
      @(negedge clock);
      bus.nickel_in  = 1'b0;
      bus.dime_in    = 1'b0;
      bus.quarter_in = 1'b0;
      bus.cancel     = 1'b0;
      reset          = 1'b0;
   endtask

   task automatic idle(int k);
      repeat (k) cyc(0, 0, 0, 0, 0);
   endtask

   initial begin
      bit n, d, q, c;
      bus.nickel_in  = 1'b0;
      bus.dime_in    = 1'b0;
      bus.quarter_in = 1'b0;
      bus.cancel     = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // reset state
      check_outs();

      // n,d,d -> exact price, no change
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      idle(3);

      // d,d,q -> credit 9, two dimes back; coins while busy ignored
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 0, 1, 0);
      idle(3);

      // n,n,n then cancel -> dime, nickel
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      idle(3);

      // quarter + nickel together credit only the quarter
      cyc(1, 0, 1, 0, 0);
      idle(3);

      // cancel with zero credit does nothing
      cyc(0, 0, 0, 1, 0);
      idle(1);

      // reset held two cycles in the middle of change
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      idle(2);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         q = ($urandom_range(0, 5) == 0);
         d = ($urandom_range(0, 3) == 0);
         n = ($urandom_range(0, 2) == 0);
         c = ($urandom_range(0, 11) == 0);
         if (c && cr == 0) begin
            n = 1'b0;
            d = 1'b0;
            q = 1'b0;
         end
         cyc(n, d, q, c, ($urandom_range(0, 199) == 0));
      end
      idle(8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
